vga_sync_timer: RTL and testbench



---
 rtl/vga_sync_timer_if.sv | 25 ++
 rtl/vga_sync_timer.sv | 136 +++++++++++++
 tb/tb_vga_sync_timer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_timer_if.sv
// Pixel-timing bundle between vga_sync_timer and the pattern/colour logic.
// The slave side is the timer; the master side owns the pixel enable and animation controls.
interface vga_sync_timer_if;
    logic       ce;
    logic       speed;
    logic       pause;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       line_start;
    logic       frame_start;
    logic [9:0] frame;

    modport master (
        output ce, speed, pause,
        input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame
    );

    modport slave (
        input  ce, speed, pause,
        output hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame
    );
endinterface

// File: rtl/vga_sync_timer.sv
// VGA pixel timing: H/V position counters with porch/sync FSMs, line/frame strobes
// and a speed-controlled animation frame counter. All outputs are registered from next-state values.
//
// state     | meaning
// ST_ACTIVE | visible pixels (H) / visible lines (V)
// ST_FRONT  | front porch
// ST_SYNC   | sync pulse asserted
// ST_BACK   | back porch, left only on counter wrap
module vga_sync_timer #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_sync_timer_if.slave  io_vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_sync_timer: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
    localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
    localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } state_t;

    state_t     r_hstate, w_hstate_nxt;
    state_t     r_vstate, w_vstate_nxt;
    logic [9:0] r_hpos, r_vpos, w_hpos_nxt, w_vpos_nxt;
    logic       w_h_wrap, w_v_wrap;
    logic       r_hsync, r_vsync, r_display_on;
    logic       r_line_start, r_frame_start;
    logic [9:0] r_frame, w_frame_nxt;

    always_comb begin
        w_h_wrap   = (r_hpos == H_LAST);
        w_v_wrap   = (r_vpos == V_LAST);
        w_hpos_nxt = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
        w_vpos_nxt = r_vpos;
        if (w_h_wrap) begin
            w_vpos_nxt = w_v_wrap ? 10'd0 : r_vpos + 10'd1;
        end
        w_frame_nxt = r_frame + (io_vga.speed ? 10'd2 : 10'd1);
    end

    // The wrap check comes first so any corrupted state is forced back to ACTIVE.
    always_comb begin
        w_hstate_nxt = r_hstate;
        if (w_h_wrap) begin
            w_hstate_nxt = ST_ACTIVE;
        end else begin
            case (r_hstate)
                ST_ACTIVE: if (w_hpos_nxt == H_FP_START) w_hstate_nxt = ST_FRONT;
                ST_FRONT:  if (w_hpos_nxt == H_SY_START) w_hstate_nxt = ST_SYNC;
                ST_SYNC:   if (w_hpos_nxt == H_BP_START) w_hstate_nxt = ST_BACK;
                default:   w_hstate_nxt = r_hstate;
            endcase
        end
    end

    always_comb begin
        w_vstate_nxt = r_vstate;
        if (w_h_wrap) begin
            if (w_v_wrap) begin
                w_vstate_nxt = ST_ACTIVE;
            end else begin
                case (r_vstate)
                    ST_ACTIVE: if (w_vpos_nxt == V_FP_START) w_vstate_nxt = ST_FRONT;
                    ST_FRONT:  if (w_vpos_nxt == V_SY_START) w_vstate_nxt = ST_SYNC;
                    ST_SYNC:   if (w_vpos_nxt == V_BP_START) w_vstate_nxt = ST_BACK;
                    default:   w_vstate_nxt = r_vstate;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_hstate      <= ST_BACK;
            r_vstate      <= ST_BACK;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame       <= 10'd0;
        end else begin
            // Strobes are single-cycle even when ce drops right after the wrap.
            r_line_start  <= io_vga.ce && w_h_wrap;
            r_frame_start <= io_vga.ce && w_h_wrap && w_v_wrap;
            if (io_vga.ce) begin
                r_hpos       <= w_hpos_nxt;
                r_vpos       <= w_vpos_nxt;
                r_hstate     <= w_hstate_nxt;
                r_vstate     <= w_vstate_nxt;
                r_hsync      <= (w_hstate_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_vsync      <= (w_vstate_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_display_on <= (w_hstate_nxt == ST_ACTIVE) && (w_vstate_nxt == ST_ACTIVE);
                if (w_h_wrap && w_v_wrap && !io_vga.pause) begin
                    r_frame <= w_frame_nxt;
                end
            end
        end
    end

    assign io_vga.hsync       = r_hsync;
    assign io_vga.vsync       = r_vsync;
    assign io_vga.display_on  = r_display_on;
    assign io_vga.hpos        = r_hpos;
    assign io_vga.vpos        = r_vpos;
    assign io_vga.line_start  = r_line_start;
    assign io_vga.frame_start = r_frame_start;
    assign io_vga.frame       = r_frame;
endmodule

// File: tb/tb_vga_sync_timer.sv
// Bench for vga_sync_timer: a reduced-geometry instance checked cycle by cycle against a
// scoreboard fed by a position-compare model, plus a default-geometry instance for reset/line timing.
module tb_vga_sync_timer;
    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 2, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CYC = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] hp;
        logic [9:0] vp;
        logic       ls;
        logic       fs;
        logic [9:0] fr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    obs_t sb_q[$];
    int   m_h, m_v, m_frame;
    logic m_ls, m_fs;

    vga_sync_timer_if ifa ();
    vga_sync_timer_if ifb ();

    assign ifb.ce    = ifa.ce;
    assign ifb.speed = ifa.speed;
    assign ifb.pause = ifa.pause;

    vga_sync_timer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0)
    ) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_vga (ifa)
    );

    vga_sync_timer dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_vga (ifb)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample_a();
        sample_a = '{ifa.hsync, ifa.vsync, ifa.display_on, ifa.hpos, ifa.vpos,
                     ifa.line_start, ifa.frame_start, ifa.frame};
    endfunction

    function automatic obs_t sample_b();
        sample_b = '{ifb.hsync, ifb.vsync, ifb.display_on, ifb.hpos, ifb.vpos,
                     ifb.line_start, ifb.frame_start, ifb.frame};
    endfunction

    function automatic void model_reset();
        m_h = HT - 1; m_v = VT - 1; m_frame = 0; m_ls = 1'b0; m_fs = 1'b0;
        sb_q.delete();
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.hs = !((m_h >= HV + HF) && (m_h < HV + HF + HS));
        o.vs = !((m_v >= VV + VF) && (m_v < VV + VF + VS));
        o.de = (m_h < HV) && (m_v < VV);
        o.hp = 10'(m_h);
        o.vp = 10'(m_v);
        o.ls = m_ls;
        o.fs = m_fs;
        o.fr = 10'(m_frame);
        return o;
    endfunction

    function automatic void model_step(input logic c, input logic s, input logic p);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (c) begin
            m_ls = (m_h == HT - 1);
            m_h  = m_ls ? 0 : m_h + 1;
            if (m_ls) begin
                m_v  = (m_v == VT - 1) ? 0 : m_v + 1;
                m_fs = (m_v == 0);
            end
            if (m_fs && !p) m_frame = (m_frame + (s ? 2 : 1)) % 1024;
        end
    endfunction

    task automatic drive_cycle(input logic c, input logic s, input logic p);
        ifa.ce = c; ifa.speed = s; ifa.pause = p;
        model_step(c, s, p);
        sb_q.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst_n = 1'b0; ifa.ce = 1'b1; ifa.speed = 1'b0; ifa.pause = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got = sample_a(); exp = model_obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_a got=%h exp=%h", got, exp); end
        got = sample_b(); exp = '{1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0, 10'd0}; checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_b got=%h exp=%h", got, exp); end
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0);
        exp = sb_q.pop_front(); got = sample_a(); checks++;
        if (got !== exp) begin errors++; $display("FAIL release_a got=%h exp=%h", got, exp); end
        got = sample_b(); exp = '{1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 10'd1}; checks++;
        if (got !== exp) begin errors++; $display("FAIL release_b got=%h exp=%h", got, exp); end
    endtask

    task automatic test_line_timing();
        obs_t got, exp;
        int   hs_low, hp;
        hs_low = 0;
        for (int i = 1; i <= 800; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            exp = sb_q.pop_front(); got = sample_a(); checks++;
            if (got !== exp) begin errors++; $display("FAIL line_a got=%h exp=%h", got, exp); end
            hp     = i % 800;
            exp.hs = !(hp >= 656 && hp < 752);
            exp.vs = 1'b1;
            exp.de = (hp < 640);
            exp.hp = 10'(hp);
            exp.vp = 10'(i / 800);
            exp.ls = (hp == 0);
            exp.fs = 1'b0;
            exp.fr = 10'd1;
            got = sample_b(); checks++;
            if (got !== exp) begin errors++; $display("FAIL line_b i=%0d got=%h exp=%h", i, got, exp); end
            if (!ifb.hsync) hs_low++;
        end
        checks++;
        if (hs_low != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
    endtask

    task automatic test_frame_timing();
        obs_t got, exp;
        int   last_fs, vs_cnt, fs_cnt;
        last_fs = -1; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            exp = sb_q.pop_front(); got = sample_a(); checks++;
            if (got !== exp) begin errors++; $display("FAIL frame_a got=%h exp=%h", got, exp); end
            if (!got.vs) vs_cnt++;
            checks++;
            if (got.de && got.vp >= VV) begin errors++; $display("FAIL de_vblank vpos=%0d", got.vp); end
            if (got.fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != FRAME_CYC) begin
                        errors++; $display("FAIL fs_period got=%0d exp=%0d", i - last_fs, FRAME_CYC);
                    end
                end
                last_fs = i;
                fs_cnt++;
            end
        end
        checks++;
        if (vs_cnt != 2 * VS * HT) begin errors++; $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, 2 * VS * HT); end
        checks++;
        if (fs_cnt != 2) begin errors++; $display("FAIL fs_count got=%0d exp=2", fs_cnt); end
    endtask

    // Each chunk of FRAME_CYC ce cycles contains exactly one (0,0) load.
    task automatic test_frame_counter();
        obs_t got, exp;
        logic spd;
        int   fs_cnt;
        for (int f = 0; f < 600 && m_frame != 1022; f++) begin
            spd = (m_frame % 2 == 0);
            for (int i = 0; i < FRAME_CYC; i++) begin
                drive_cycle(1'b1, spd, 1'b0);
                exp = sb_q.pop_front(); got = sample_a(); checks++;
                if (got !== exp) begin errors++; $display("FAIL cnt_up got=%h exp=%h", got, exp); end
            end
        end
        checks++;
        if (ifa.frame !== 10'd1022) begin errors++; $display("FAIL reach_1022 got=%0d", ifa.frame); end
        for (int i = 0; i < FRAME_CYC; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0);
            exp = sb_q.pop_front(); got = sample_a(); checks++;
            if (got !== exp) begin errors++; $display("FAIL cnt_wrap2 got=%h exp=%h", got, exp); end
        end
        checks++;
        if (ifa.frame !== 10'd0) begin errors++; $display("FAIL wrap_speed1 got=%0d exp=0", ifa.frame); end
        for (int f = 0; f < 600 && m_frame != 1023; f++) begin
            spd = (m_frame % 2 == 0) && (m_frame != 1022);
            for (int i = 0; i < FRAME_CYC; i++) begin
                drive_cycle(1'b1, spd, 1'b0);
                exp = sb_q.pop_front(); got = sample_a(); checks++;
                if (got !== exp) begin errors++; $display("FAIL cnt_up2 got=%h exp=%h", got, exp); end
            end
        end
        checks++;
        if (ifa.frame !== 10'd1023) begin errors++; $display("FAIL reach_1023 got=%0d", ifa.frame); end
        for (int i = 0; i < FRAME_CYC; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            exp = sb_q.pop_front(); got = sample_a(); checks++;
            if (got !== exp) begin errors++; $display("FAIL cnt_wrap1 got=%h exp=%h", got, exp); end
        end
        checks++;
        if (ifa.frame !== 10'd0) begin errors++; $display("FAIL wrap_speed0 got=%0d exp=0", ifa.frame); end
        fs_cnt = 0;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1);
            exp = sb_q.pop_front(); got = sample_a(); checks++;
            if (got !== exp) begin errors++; $display("FAIL pause_sb got=%h exp=%h", got, exp); end
            if (got.fs) fs_cnt++;
            checks++;
            if (got.fr !== 10'd0) begin errors++; $display("FAIL pause_hold got=%0d exp=0", got.fr); end
        end
        checks++;
        if (fs_cnt != 3) begin errors++; $display("FAIL pause_fs got=%0d exp=3", fs_cnt); end
    endtask

    task automatic test_ce_gating();
        obs_t got, exp, prev, hold;
        logic c;
        for (int i = 0; i < 12 * HT; i++) begin
            c    = (i % 2 == 0);
            prev = sample_a();
            drive_cycle(c, 1'b0, 1'b0);
            exp = sb_q.pop_front(); got = sample_a(); checks++;
            if (got !== exp) begin errors++; $display("FAIL ce_sb got=%h exp=%h", got, exp); end
            checks++;
            if (!c) begin
                hold = prev; hold.ls = 1'b0; hold.fs = 1'b0;
                if (got !== hold) begin errors++; $display("FAIL ce_hold got=%h exp=%h", got, hold); end
            end else if (got.hp !== 10'((int'(prev.hp) + 1) % HT)) begin
                errors++; $display("FAIL ce_advance got=%0d prev=%0d", got.hp, prev.hp);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        for (int i = 0; i < 2 * FRAME_CYC && !(m_h == HV + HF && m_v == VV + VF); i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            exp = sb_q.pop_front(); got = sample_a(); checks++;
            if (got !== exp) begin errors++; $display("FAIL seek_sync got=%h exp=%h", got, exp); end
        end
        checks++;
        if (ifa.hsync !== 1'b0 || ifa.vsync !== 1'b0) begin
            errors++; $display("FAIL in_sync got hs=%b vs=%b exp 0 0", ifa.hsync, ifa.vsync);
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        got = sample_a(); exp = model_obs(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset_a got=%h exp=%h", got, exp); end
        got = sample_b(); exp = '{1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0, 10'd0}; checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset_b got=%h exp=%h", got, exp); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b0);
        exp = sb_q.pop_front(); got = sample_a(); checks++;
        if (got !== exp) begin errors++; $display("FAIL restart_a got=%h exp=%h", got, exp); end
        exp = '{1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 10'd1}; checks++;
        if (got !== exp) begin errors++; $display("FAIL restart_a_const got=%h exp=%h", got, exp); end
        got = sample_b(); checks++;
        if (got !== exp) begin errors++; $display("FAIL restart_b got=%h exp=%h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_ce_gating();
        test_frame_counter();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
